// File: rtl/lane_pulse_arbiter.sv
// Round-robin merge of per-lane rising-edge events into one shaped pulse stream.
// Define LANE_SYNC_EN to insert a 2-flop synchronizer on every i_Lane_Req bit.
module lane_pulse_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int PULSE_HIGH = 4,
  parameter int PULSE_LOW  = 4,
  parameter int PEND_W     = 3
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [NUM_LANES-1:0] i_Lane_Req,
  input  logic                 i_Enable,
  output logic                 o_Pulse,
  output logic [NUM_LANES-1:0] o_Grant,
  output logic                 o_Busy,
  output logic [NUM_LANES-1:0] o_Overflow
);

  localparam int LG_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int T_MAX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [TMR_W-1:0]  HIGH_LOAD = TMR_W'(PULSE_HIGH - 1);
  localparam logic [TMR_W-1:0]  LOW_LOAD  = TMR_W'(PULSE_LOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LG_W-1:0] idx);
    return {{(NUM_LANES-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [NUM_LANES-1:0] req_s;
  logic [NUM_LANES-1:0] prev_r;
  logic [NUM_LANES-1:0] event_s;
  logic [NUM_LANES-1:0] nonzero_s;
  logic [NUM_LANES-1:0] dec_s;
  logic [NUM_LANES-1:0] ovf_s;
  logic [LG_W-1:0]      last_grant_r;
  logic [LG_W-1:0]      win_idx_s;
  logic                 win_found_s;
  logic                 grant_fire_s;
  state_t               state_r, state_nxt_s;
  logic [TMR_W-1:0]     tmr_r, tmr_nxt_s;
  logic                 pulse_nxt_s, busy_nxt_s;
  logic [NUM_LANES-1:0] grant_nxt_s;
  logic                 pulse_r, busy_r;
  logic [NUM_LANES-1:0] grant_r;

`ifdef LANE_SYNC_EN
  logic [NUM_LANES-1:0] sync1_r, sync2_r;

  // Two-stage synchronizer for asynchronous lane inputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_r <= {NUM_LANES{1'b0}};
      sync2_r <= {NUM_LANES{1'b0}};
    end else begin
      sync1_r <= i_Lane_Req;
      sync2_r <= sync1_r;
    end
  end
  assign req_s = sync2_r;
`else
  assign req_s = i_Lane_Req;
`endif

  // Previous-sample register; reset to 0 so a lane held high counts once
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      prev_r <= {NUM_LANES{1'b0}};
    end else begin
      prev_r <= req_s;
    end
  end
  assign event_s = req_s & ~prev_r;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [PEND_W-1:0] cnt_r;
      logic              ovf_r;

      // Saturating pending counter; a simultaneous event and grant cancel out
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          cnt_r <= {PEND_W{1'b0}};
          ovf_r <= 1'b0;
        end else if (event_s[g] && !dec_s[g]) begin
          if (cnt_r == PEND_MAX) begin
            ovf_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + PEND_W'(1);
          end
        end else if (!event_s[g] && dec_s[g] && (cnt_r != {PEND_W{1'b0}})) begin
          cnt_r <= cnt_r - PEND_W'(1);
        end
      end
      assign nonzero_s[g] = (cnt_r != {PEND_W{1'b0}});
      assign ovf_s[g]     = ovf_r;
    end
  endgenerate

  // Round-robin search starting just after the last granted lane
  always_comb begin
    logic [LG_W-1:0] idx_s;
    win_found_s = 1'b0;
    win_idx_s   = {LG_W{1'b0}};
    idx_s       = {LG_W{1'b0}};
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx_s = LG_W'((int'(last_grant_r) + i) % NUM_LANES);
      if (!win_found_s && nonzero_s[idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign grant_fire_s = (state_r == ST_IDLE) && i_Enable && win_found_s;
  assign dec_s        = grant_fire_s ? lane_onehot(win_idx_s) : {NUM_LANES{1'b0}};

  // Round-robin pointer; reset value gives lane 0 first priority
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      last_grant_r <= LG_W'(NUM_LANES - 1);
    end else if (grant_fire_s) begin
      last_grant_r <= win_idx_s;
    end
  end

  // FSM state and width timer
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= ST_IDLE;
      tmr_r   <= {TMR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_fire_s) begin
          state_nxt_s = ST_HIGH;
          tmr_nxt_s   = HIGH_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (tmr_r == {TMR_W{1'b0}}) begin
          state_nxt_s = ST_LOW;
          tmr_nxt_s   = LOW_LOAD;
        end else begin
          tmr_nxt_s = tmr_r - TMR_W'(1);
        end
      end
      ST_LOW: begin
        if (tmr_r == {TMR_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
          tmr_nxt_s   = {TMR_W{1'b0}};
        end else begin
          tmr_nxt_s = tmr_r - TMR_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tmr_nxt_s   = {TMR_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the registered outputs align with it
  always_comb begin
    pulse_nxt_s = (state_nxt_s == ST_HIGH);
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    grant_nxt_s = {NUM_LANES{1'b0}};
    case (state_nxt_s)
      ST_IDLE: grant_nxt_s = {NUM_LANES{1'b0}};
      default: begin
        if (state_r == ST_IDLE) begin
          grant_nxt_s = lane_onehot(win_idx_s);
        end else begin
          grant_nxt_s = grant_r;
        end
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      grant_r <= {NUM_LANES{1'b0}};
    end else begin
      pulse_r <= pulse_nxt_s;
      busy_r  <= busy_nxt_s;
      grant_r <= grant_nxt_s;
    end
  end

  assign o_Pulse    = pulse_r;
  assign o_Busy     = busy_r;
  assign o_Grant    = grant_r;
  assign o_Overflow = ovf_s;

endmodule

// File: tb/tb_lane_pulse_arbiter.sv
// Directed self-checking bench for lane_pulse_arbiter (default parameters).
module tb_lane_pulse_arbiter;

`ifdef LANE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int LIMIT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       en = 1'b0;
  logic       pulse;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] ovf;

  int checks = 0;
  int failures = 0;
  int n;
  logic [3:0] fair_exp [4];

  always #5 clk = ~clk;

  lane_pulse_arbiter #(
    .NUM_LANES(4), .PULSE_HIGH(4), .PULSE_LOW(4), .PEND_W(3)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Lane_Req(req), .i_Enable(en),
    .o_Pulse(pulse), .o_Grant(grant), .o_Busy(busy), .o_Overflow(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Cycles until the next 0->1 of o_Pulse; -1 if the bound expires
  task automatic wait_rise(output int cnt);
    cnt = 0;
    while (pulse === 1'b1 && cnt < LIMIT) begin
      tick();
      cnt++;
    end
    while (pulse !== 1'b1 && cnt < LIMIT) begin
      tick();
      cnt++;
    end
    if (cnt >= LIMIT) cnt = -1;
  endtask

  task automatic count_rises(input int cycles, output int cnt);
    logic prev;
    cnt = 0;
    prev = pulse;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (pulse === 1'b1 && prev !== 1'b1) cnt++;
      prev = pulse;
    end
  endtask

  initial begin
    fair_exp[0] = 4'b0001;
    fair_exp[1] = 4'b1000;
    fair_exp[2] = 4'b0001;
    fair_exp[3] = 4'b1000;

    // Reset state
    tick();
    tick();
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single event on lane 2
    en = 1'b1;
    req = 4'b0100;
    wait_rise(n);
    chk("single_latency", 32'(n), 32'(2 + LAT));
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      chk("single_pulse", 32'(pulse), (i < 4) ? 32'd1 : 32'd0);
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("single_grant_end", 32'(grant), 32'd0);
    chk("single_busy_end", 32'(busy), 32'd0);
    count_rises(30, n);
    chk("single_no_extra", 32'(n), 32'd0);

    // Fairness: lanes 0 and 3 receive two events each in the same cycles
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req = 4'b1001;
      tick();
      req = 4'b0000;
      tick();
    end
    repeat (4) tick();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rise(n);
      chk("fair_spacing", 32'(n), (k == 0) ? 32'd1 : 32'd9);
      chk("fair_grant", 32'(grant), 32'(fair_exp[k]));
    end
    count_rises(30, n);
    chk("fair_no_extra", 32'(n), 32'd0);

    // Saturation: nine events on lane 1 while disabled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
    end
    repeat (4) tick();
    chk("sat_no_pulse", 32'(pulse), 32'd0);
    chk("sat_ovf", 32'(ovf), 32'h2);
    en = 1'b1;
    count_rises(100, n);
    chk("sat_pulses", 32'(n), 32'd7);
    chk("sat_ovf_held", 32'(ovf), 32'h2);
    do_reset();
    chk("sat_ovf_cleared", 32'(ovf), 32'd0);

    // Event arriving in the same cycle lane 0 is granted with pending=1
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (4) tick();
    req = 4'b0001;
    repeat (LAT) tick();
    en = 1'b1;
    wait_rise(n);
    chk("conc_first", 32'(n), 32'd1);
    chk("conc_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    count_rises(40, n);
    chk("conc_second", 32'(n), 32'd1);

    // Reset asserted mid-pulse with three events still pending
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
    end
    repeat (4) tick();
    en = 1'b1;
    wait_rise(n);
    chk("rmid_rise", 32'(n), 32'd1);
    tick();
    chk("rmid_high", 32'(pulse), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_pulse_async", 32'(pulse), 32'd0);
    chk("rmid_grant_async", 32'(grant), 32'd0);
    chk("rmid_busy_async", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    count_rises(40, n);
    chk("rmid_discarded", 32'(n), 32'd0);
    req = 4'b0001;
    wait_rise(n);
    chk("rmid_new_event", 32'(n), 32'(2 + LAT));
    req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
